// File: rtl/wu_fetch_pkg.sv
// wu_fetch_pkg: shared types and constants for the WU instruction fetch stage.
//   - manager address / id widths used by the fetch ports
//   - fetch FSM state encoding (2-bit)
//   - credit counter width and instruction-memory read latency
//   - wuf_popcount: counts set bits of the in-flight read history
package wu_fetch_pkg;

  localparam int unsigned MGR_WU_ADDRESS_WIDTH = 10;
  localparam int unsigned MGR_MGR_ID_WIDTH     = 6;

  localparam int unsigned WUF_CREDIT_WIDTH = 4;
  localparam int unsigned WUF_MEM_LATENCY  = 2;

  typedef enum logic [1:0] {
    WUF_STATE_IDLE  = 2'd0,
    WUF_STATE_RUN   = 2'd1,
    WUF_STATE_DRAIN = 2'd2
  } wuf_state_e;

  function automatic logic [WUF_CREDIT_WIDTH-1:0] wuf_popcount(
    input logic [WUF_MEM_LATENCY-1:0] v
  );
    logic [WUF_CREDIT_WIDTH-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WUF_MEM_LATENCY; i++) begin
      n = n + WUF_CREDIT_WIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/wu_fetch_credit.sv
// wu_fetch_credit: decode-side credit bookkeeping for the WU fetch stage.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   issue            a read is being launched this cycle (strobe visible next cycle)
//   credit_return    decode popped one word
//   refund_en        a jump is taken this cycle; reads still in flight are refunded
//   credit_avail     at least one credit is held
//   credit_err       sticky: credit returned while already holding CREDITS
module wu_fetch_credit
  import wu_fetch_pkg::*;
#(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic credit_return,
  input  logic refund_en,
  output logic credit_avail,
  output logic credit_err
);

  localparam int unsigned SW = WUF_CREDIT_WIDTH + 2;
  localparam logic [WUF_CREDIT_WIDTH-1:0] CMAX   = WUF_CREDIT_WIDTH'(CREDITS);
  localparam logic [SW-1:0]               CMAX_W = SW'(CREDITS);

  logic [WUF_CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [WUF_MEM_LATENCY-1:0]  rd_hist_q;
  logic [WUF_CREDIT_WIDTH-1:0] refund;
  logic [SW-1:0]               sum;
  logic                        err_set;

  // rd_hist[0] is the strobe visible this cycle, rd_hist[1] the one before;
  // together they are exactly the wrong-path words decode will drop on a jump.
  assign refund  = refund_en ? wuf_popcount(rd_hist_q) : '0;
  assign err_set = credit_return && !issue && (credits_q == CMAX);

  always_comb begin
    sum = SW'(credits_q) - SW'(issue) + SW'(credit_return) + SW'(refund);
    if (sum > CMAX_W) begin
      sum = CMAX_W;
    end
    credits_d = sum[WUF_CREDIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= CMAX;
      rd_hist_q  <= '0;
      credit_err <= 1'b0;
    end else begin
      credits_q <= credits_d;
      rd_hist_q <= {rd_hist_q[WUF_MEM_LATENCY-2:0], issue};
      if (err_set) begin
        credit_err <= 1'b1;
      end
    end
  end

  assign credit_avail = (credits_q != '0);

endmodule

// File: rtl/wu_fetch.sv
// wu_fetch: work-unit instruction fetch stage. Drives registered read
// address/strobe into the WU instruction memory (data reaches decode two
// cycles after the strobe), flow-controlled by decode credits, redirected by
// decode jump/halt.
// Ports:
//   clk, reset_poweron_n          clock, asynchronous active-low reset
//   sys__mgr__mgrId               manager id (debug only, not used by logic)
//   sys__wuf__start/_start_addr   begin fetching at start_addr (IDLE only)
//   wud__wuf__credit              decode popped one word
//   wud__wuf__jump/_jump_addr     redirect fetch
//   wud__wuf__halt                program complete; drain and go idle
//   wuf__wum__addr/_read          registered read address / strobe
//   wuf__sys__busy                state != IDLE
//   wuf__sys__credit_err          sticky credit overflow flag
// Optional (WU_FETCH_PERF_CNT_EN): wuf__sys__reads_issued and
//   wuf__sys__stall_cycles, 32-bit saturating counters cleared on start.
module wu_fetch
  import wu_fetch_pkg::*;
#(
  parameter int unsigned CREDITS     = 4,
  parameter int unsigned MEM_DEPTH   = 2 ** MGR_WU_ADDRESS_WIDTH,
  parameter int unsigned MEM_LATENCY = WUF_MEM_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset_poweron_n,
  input  logic [MGR_MGR_ID_WIDTH-1:0]     sys__mgr__mgrId,
  input  logic                            sys__wuf__start,
  input  logic [MGR_WU_ADDRESS_WIDTH-1:0] sys__wuf__start_addr,
  input  logic                            wud__wuf__credit,
  input  logic                            wud__wuf__jump,
  input  logic [MGR_WU_ADDRESS_WIDTH-1:0] wud__wuf__jump_addr,
  input  logic                            wud__wuf__halt,
  output logic [MGR_WU_ADDRESS_WIDTH-1:0] wuf__wum__addr,
  output logic                            wuf__wum__read,
  output logic                            wuf__sys__busy,
  output logic                            wuf__sys__credit_err
`ifdef WU_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                     wuf__sys__reads_issued,
  output logic [31:0]                     wuf__sys__stall_cycles
`endif
);

  localparam logic [MGR_WU_ADDRESS_WIDTH-1:0] LAST_ADDR = MGR_WU_ADDRESS_WIDTH'(MEM_DEPTH - 1);
  // The halt cycle itself counts as the first drain cycle, so DRAIN lasts
  // MEM_LATENCY-1 cycles and busy falls two cycles after halt.
  localparam logic [1:0] DRAIN_LOAD = 2'(MEM_LATENCY - 2);

  wuf_state_e                      state_q, state_d;
  logic [MGR_WU_ADDRESS_WIDTH-1:0] pc_q, pc_d, issue_addr;
  logic [1:0]                      drain_q, drain_d;
  logic                            issue, refund_en, credit_avail;
  logic                            unused_mgr_id;

  assign unused_mgr_id = ^sys__mgr__mgrId;

  function automatic logic [MGR_WU_ADDRESS_WIDTH-1:0] next_pc(
    input logic [MGR_WU_ADDRESS_WIDTH-1:0] a
  );
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Issue decision is combinational and the strobe is registered, so a read
  // decided in cycle N is visible (and counted as issued) in cycle N+1.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drain_d    = drain_q;
    issue      = 1'b0;
    issue_addr = pc_q;
    refund_en  = 1'b0;
    unique case (state_q)
      WUF_STATE_IDLE: begin
        if (sys__wuf__start) begin
          state_d    = WUF_STATE_RUN;
          issue_addr = sys__wuf__start_addr;
          issue      = credit_avail;
          pc_d       = credit_avail ? next_pc(sys__wuf__start_addr) : sys__wuf__start_addr;
        end
      end
      WUF_STATE_RUN: begin
        if (wud__wuf__halt) begin
          state_d = WUF_STATE_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (wud__wuf__jump) begin
          pc_d      = wud__wuf__jump_addr;
          refund_en = 1'b1;
        end else if (credit_avail) begin
          issue = 1'b1;
          pc_d  = next_pc(pc_q);
        end
      end
      WUF_STATE_DRAIN: begin
        if (drain_q == '0) begin
          state_d = WUF_STATE_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = WUF_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q        <= WUF_STATE_IDLE;
      pc_q           <= '0;
      drain_q        <= '0;
      wuf__wum__read <= 1'b0;
      wuf__wum__addr <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drain_q        <= drain_d;
      wuf__wum__read <= issue;
      if (issue) begin
        wuf__wum__addr <= issue_addr;
      end
    end
  end

  assign wuf__sys__busy = (state_q != WUF_STATE_IDLE);

  wu_fetch_credit #(
    .CREDITS(CREDITS)
  ) u_credit (
    .clk          (clk),
    .rst_n        (reset_poweron_n),
    .issue        (issue),
    .credit_return(wud__wuf__credit),
    .refund_en    (refund_en),
    .credit_avail (credit_avail),
    .credit_err   (wuf__sys__credit_err)
  );

`ifdef WU_FETCH_PERF_CNT_EN
  logic perf_clr;
  assign perf_clr = (state_q == WUF_STATE_IDLE) && sys__wuf__start;

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      wuf__sys__reads_issued <= '0;
      wuf__sys__stall_cycles <= '0;
    end else if (perf_clr) begin
      wuf__sys__reads_issued <= 32'(issue);
      wuf__sys__stall_cycles <= '0;
    end else begin
      if (issue && (wuf__sys__reads_issued != '1)) begin
        wuf__sys__reads_issued <= wuf__sys__reads_issued + 1'b1;
      end
      if ((state_q == WUF_STATE_RUN) && !credit_avail && (wuf__sys__stall_cycles != '1)) begin
        wuf__sys__stall_cycles <= wuf__sys__stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/wu_fetch.md
Name: wu_fetch

Overview:
- Work-unit instruction fetch stage for the manager; drives read address/strobe into the WU instruction memory, which returns the word to WU decode two cycles later.
- Sequences addresses from a start address, honours decode-side credit flow control, and redirects on decode jump/halt.
- On redirect, refunds credits for in-flight wrong-path reads.

Parameters:
- CREDITS, 4: decode input-FIFO depth; initial credit count (1..15).
- MEM_DEPTH, 2^`MGR_WU_ADDRESS_WIDTH: instruction memory depth; address wraps at MEM_DEPTH-1.
- MEM_LATENCY, 2: read-strobe-to-output cycles of the instruction memory (fixed at 2).

Ports:
- clk  in  1  clock
- reset_poweron_n  in  1  asynchronous, active-low reset
- sys__mgr__mgrId  in  `MGR_MGR_ID_RANGE  manager id (debug only)
- sys__wuf__start  in  1  pulse: begin fetching at start_addr
- sys__wuf__start_addr  in  `MGR_WU_ADDRESS_RANGE  program entry address
- wud__wuf__credit  in  1  pulse: decode popped one word
- wud__wuf__jump  in  1  pulse: redirect fetch
- wud__wuf__jump_addr  in  `MGR_WU_ADDRESS_RANGE  redirect target
- wud__wuf__halt  in  1  pulse: program complete
- wuf__wum__addr  out  `MGR_WU_ADDRESS_RANGE  read address (registered)
- wuf__wum__read  out  1  read strobe (registered)
- wuf__sys__busy  out  1  state != IDLE
- wuf__sys__credit_err  out  1  sticky: credit returned at CREDITS

Behaviour:
- Reset: state=IDLE, pc=0, credits=CREDITS, rd_hist=0; all outputs 0.
- States:
  - IDLE: on start, pc<=start_addr, go RUN.
  - RUN: each cycle with credits>0, assert read with addr=pc; pc<=pc+1, wrapping MEM_DEPTH-1 -> 0.
  - RUN exits: halt -> DRAIN; jump -> pc<=jump_addr and stay in RUN.
  - DRAIN: no reads; wait MEM_LATENCY cycles so all in-flight words reach decode, then go IDLE.
- Credits:
  - next = credits - read_issued + credit_return + refund.
  - credit_return with credits==CREDITS and no read issued: hold at CREDITS, set credit_err.
- rd_hist: MEM_LATENCY-bit shift register of issued reads.
- Jump, sampled in cycle J:
  - Reads issued in J-1 and J arrive at decode in J+1 and J+2; decode discards them and returns no credit for them.
  - Fetch refunds popcount(rd_hist incl. the cycle-J read) in cycle J+1.
  - No read is issued in cycle J+1; first read at jump_addr is issued in cycle J+2.
- Halt:
  - Suppresses any read in the cycle it is sampled.
  - Same-cycle halt+jump: halt wins; jump ignored, no refund.
- Start:
  - Ignored unless IDLE.
  - Start in the same cycle as the final DRAIN->IDLE transition is ignored.
- Latency: start sampled in cycle S -> first wuf__wum__read in S+1.
- Reset mid-RUN: outputs drop immediately (async); in-flight memory words are decode's responsibility.
- Credits never go negative; when credits==0, read is held low, pc is held, and busy stays 1.

Optional Feature:
- Macro: WU_FETCH_PERF_CNT_EN.
- With the macro: adds 32-bit outputs wuf__sys__reads_issued and wuf__sys__stall_cycles.
  - stall_cycles counts RUN cycles with credits==0.
  - Both counters saturate and clear on start.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- wu_fetch.vh holds:
  - state encodings WUF_STATE_IDLE/RUN/DRAIN (2-bit);
  - WUF_CREDIT_WIDTH (4);
  - WUF_MEM_LATENCY (2).
- Address width/range macros come from the existing manager.vh.
- One natural sub-module: wu_fetch_credit, which holds the credit counter, rd_hist shift register, refund popcount and the error flag.

Test Plan:
- Basic stream: start_addr=0x10, CREDITS=4, no credit returns -> reads at 0x10..0x13 in consecutive cycles, then read=0 with busy=1.
- Steady flow: credit pulse every cycle after the 4th read -> one read per cycle, addresses contiguous, credits stable at 0/1.
- Jump: jump to 0x40 in cycle J while credits plentiful -> refund 2, no read in J+1, read addr 0x40 in J+2, credits restored to pre-jump value minus outstanding.
- Wrap: start_addr=MEM_DEPTH-2 -> addresses MEM_DEPTH-2, MEM_DEPTH-1, 0, 1.
- Halt and reset: halt+jump same cycle -> no further reads, busy falls 2 cycles later. Separately, reset_poweron_n asserted mid-RUN -> read=0 and addr=0 immediately, credits=CREDITS after release.
- Credit error: extra credit pulse in IDLE -> credit_err=1 and stays set, credits remain CREDITS.
